// File: rtl/wb_dma_irq_pkg.sv
// Shared types for the DMA interrupt controller: line FSM state encoding and channel limit.
package wb_dma_irq_pkg;

    localparam int MAX_CH = 32;

    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_ACTIVE = 2'd1,
        IRQ_HOLD   = 2'd2
    } irq_state_e;

endpackage

// File: rtl/wb_dma_irq_line.sv
// One interrupt output line: IDLE/ACTIVE/HOLD state machine with hold-off counter.
// The output is a flop decoded from the next state, so it tracks ACTIVE exactly.
module wb_dma_irq_line
    import wb_dma_irq_pkg::*;
#(
    parameter int HOLDOFF_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
    output logic                 irq_o
);

    irq_state_e           state_q, state_d;
    logic [HOLDOFF_W-1:0] cnt_q, cnt_d;
    logic                 irq_q, irq_d;

    // State, counter and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IRQ_IDLE;
            cnt_q   <= {HOLDOFF_W{1'b0}};
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
        end
    end

    // Next state; holdoff_i is only looked at on the ACTIVE->HOLD transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = {HOLDOFF_W{1'b0}};
        case (state_q)
            IRQ_IDLE: begin
                if (req_i) state_d = IRQ_ACTIVE;
                else       state_d = IRQ_IDLE;
            end
            IRQ_ACTIVE: begin
                if (req_i) begin
                    state_d = IRQ_ACTIVE;
                end else if (holdoff_i == {HOLDOFF_W{1'b0}}) begin
                    state_d = IRQ_IDLE;
                end else begin
                    state_d = IRQ_HOLD;
                    cnt_d   = holdoff_i;
                end
            end
            IRQ_HOLD: begin
                // A count of 0 cannot occur here, but exit rather than wrap if it does.
                if (cnt_q <= HOLDOFF_W'(1)) begin
                    state_d = IRQ_IDLE;
                end else begin
                    state_d = IRQ_HOLD;
                    cnt_d   = cnt_q - HOLDOFF_W'(1);
                end
            end
            default: begin
                state_d = IRQ_IDLE;
            end
        endcase
    end

    // Output decode from the next state.
    always_comb begin
        if (state_d == IRQ_ACTIVE) irq_d = 1'b1;
        else                       irq_d = 1'b0;
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/wb_dma_irq_ctrl.sv
// DMA interrupt controller: sticky pending capture with W1C, A/B masking, per-line hold-off.
// Optional macro WB_DMA_IRQ_CTRL_ERR_EN keeps channel errors in a separate err_pend_o register.
module wb_dma_irq_ctrl
    import wb_dma_irq_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int HOLDOFF_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_CH-1:0]    ch_done_i,
    input  logic [NUM_CH-1:0]    ch_err_i,
    input  logic [NUM_CH-1:0]    mask_a_i,
    input  logic [NUM_CH-1:0]    mask_b_i,
    input  logic                 clr_we_i,
    input  logic [NUM_CH-1:0]    clr_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
    output logic [NUM_CH-1:0]    pend_o,
    output logic [NUM_CH-1:0]    err_pend_o,
    output logic                 inta_o,
    output logic                 intb_o
);

    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] err_q, err_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] done_set_s, err_set_s, clr_mask_s, src_s;
    logic              req_a_s, req_b_s;
`ifdef WB_DMA_IRQ_CTRL_ERR_EN
    logic [NUM_CH-1:0] err_pend_q, err_pend_d;
`endif

    // Edge detect and pending next state; the OR of the set vector makes set beat clear.
    always_comb begin
        done_d     = ch_done_i;
        err_d      = ch_err_i;
        done_set_s = ch_done_i & ~done_q;
        err_set_s  = ch_err_i & ~err_q;
        if (clr_we_i) clr_mask_s = clr_i;
        else          clr_mask_s = {NUM_CH{1'b0}};
`ifdef WB_DMA_IRQ_CTRL_ERR_EN
        pend_d     = (pend_q & ~clr_mask_s) | done_set_s;
        err_pend_d = (err_pend_q & ~clr_mask_s) | err_set_s;
        src_s      = pend_q | err_pend_q;
`else
        pend_d     = (pend_q & ~clr_mask_s) | done_set_s | err_set_s;
        src_s      = pend_q;
`endif
        req_a_s    = |(src_s & mask_a_i);
        req_b_s    = |(src_s & mask_b_i);
    end

    // Edge-detect history and pending registers; history resets low so a source high at release fires.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            done_q <= {NUM_CH{1'b0}};
            err_q  <= {NUM_CH{1'b0}};
            pend_q <= {NUM_CH{1'b0}};
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            pend_q <= pend_d;
        end
    end

`ifdef WB_DMA_IRQ_CTRL_ERR_EN
    // Error pending register, cleared by the same W1C strobe as pend.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) err_pend_q <= {NUM_CH{1'b0}};
        else        err_pend_q <= err_pend_d;
    end

    assign err_pend_o = err_pend_q;
`else
    assign err_pend_o = {NUM_CH{1'b0}};
`endif

    assign pend_o = pend_q;

    wb_dma_irq_line #(.HOLDOFF_W(HOLDOFF_W)) u_line_a (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_a_s),
        .holdoff_i (holdoff_i),
        .irq_o     (inta_o)
    );

    wb_dma_irq_line #(.HOLDOFF_W(HOLDOFF_W)) u_line_b (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_b_s),
        .holdoff_i (holdoff_i),
        .irq_o     (intb_o)
    );

endmodule

// File: tb/tb_wb_dma_irq_ctrl.sv
// Directed table-driven bench for wb_dma_irq_ctrl (NUM_CH=8, HOLDOFF_W=8).
module tb_wb_dma_irq_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] ch_done_i, ch_err_i, mask_a_i, mask_b_i, clr_i, holdoff_i;
    logic       clr_we_i;
    logic [7:0] pend_o, err_pend_o;
    logic       inta_o, intb_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    wb_dma_irq_ctrl #(.NUM_CH(8), .HOLDOFF_W(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ch_done_i  (ch_done_i),
        .ch_err_i   (ch_err_i),
        .mask_a_i   (mask_a_i),
        .mask_b_i   (mask_b_i),
        .clr_we_i   (clr_we_i),
        .clr_i      (clr_i),
        .holdoff_i  (holdoff_i),
        .pend_o     (pend_o),
        .err_pend_o (err_pend_o),
        .inta_o     (inta_o),
        .intb_o     (intb_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] done;
        logic [7:0] err;
        logic [7:0] ma;
        logic [7:0] mb;
        logic       cwe;
        logic [7:0] clr;
        logic [7:0] ho;
        logic [7:0] e_pend;
        logic [7:0] e_err;
        logic       e_a;
        logic       e_b;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag, input logic [7:0] ep, input logic [7:0] ee,
                             input logic ea, input logic eb);
        check({tag, " pend"},     {24'd0, pend_o},     {24'd0, ep});
        check({tag, " err_pend"}, {24'd0, err_pend_o}, {24'd0, ee});
        check({tag, " inta"},     {31'd0, inta_o},     {31'd0, ea});
        check({tag, " intb"},     {31'd0, intb_o},     {31'd0, eb});
    endtask

    // Drive inputs just after a falling edge, then compare one rising edge later.
    task automatic step_chk(input string tag, input logic [7:0] ep, input logic [7:0] ee,
                            input logic ea, input logic eb);
        @(negedge clk_i);
        check_all(tag, ep, ee, ea, eb);
    endtask

    initial begin
        //          done   err    ma     mb     cwe   clr    ho   | pend   err    a     b
        tbl[0]  = '{8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'd4, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{8'h08, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'd4, 8'h08, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{8'h08, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'd4, 8'h08, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'd4, 8'h08, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{8'h00, 8'h00, 8'hFF, 8'h00, 1'b1, 8'h08, 8'd4, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[5]  = '{8'h20, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'd4, 8'h20, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{8'h20, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'd4, 8'h20, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{8'h20, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'd4, 8'h20, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{8'h20, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'd4, 8'h20, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{8'h20, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'd4, 8'h20, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{8'h20, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'd4, 8'h20, 8'h00, 1'b1, 1'b0};
        tbl[11] = '{8'h24, 8'h00, 8'hFF, 8'h00, 1'b1, 8'h24, 8'd4, 8'h04, 8'h00, 1'b1, 1'b0};
        tbl[12] = '{8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'd4, 8'h04, 8'h00, 1'b1, 1'b0};
        tbl[13] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'd2, 8'h04, 8'h00, 1'b0, 1'b0};
        tbl[14] = '{8'h00, 8'h00, 8'h04, 8'h00, 1'b0, 8'h00, 8'd9, 8'h04, 8'h00, 1'b0, 1'b0};
        tbl[15] = '{8'h00, 8'h00, 8'h04, 8'h00, 1'b0, 8'h00, 8'd9, 8'h04, 8'h00, 1'b0, 1'b0};
        tbl[16] = '{8'h00, 8'h00, 8'h04, 8'h00, 1'b0, 8'h00, 8'd9, 8'h04, 8'h00, 1'b1, 1'b0};
        tbl[17] = '{8'h00, 8'h00, 8'h04, 8'h04, 1'b0, 8'h00, 8'd9, 8'h04, 8'h00, 1'b1, 1'b1};
        tbl[18] = '{8'h00, 8'h00, 8'h04, 8'h04, 1'b1, 8'hFF, 8'd9, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[19] = '{8'h01, 8'h00, 8'h04, 8'h04, 1'b0, 8'h00, 8'd9, 8'h01, 8'h00, 1'b0, 1'b0};

        rst_i     = 1'b0;
        ch_done_i = 8'h00;
        ch_err_i  = 8'h00;
        mask_a_i  = 8'hFF;
        mask_b_i  = 8'h00;
        clr_we_i  = 1'b0;
        clr_i     = 8'h00;
        holdoff_i = 8'd4;
        repeat (3) @(negedge clk_i);
        check_all("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        rst_i = 1'b1;

        for (int i = 0; i < 20; i++) begin
            ch_done_i = tbl[i].done;
            ch_err_i  = tbl[i].err;
            mask_a_i  = tbl[i].ma;
            mask_b_i  = tbl[i].mb;
            clr_we_i  = tbl[i].cwe;
            clr_i     = tbl[i].clr;
            holdoff_i = tbl[i].ho;
            step_chk($sformatf("vec%0d", i), tbl[i].e_pend, tbl[i].e_err, tbl[i].e_a, tbl[i].e_b);
        end

        // Asynchronous reset in the middle of a hold-off window, ch_done_i[0] kept high.
        mask_a_i = 8'hFF;
        repeat (4) @(negedge clk_i);
        check_all("pre_rst", 8'h01, 8'h00, 1'b0, 1'b0);
        #2;
        rst_i = 1'b0;
        #1;
        check_all("async_rst", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        step_chk("rel1", 8'h01, 8'h00, 1'b0, 1'b0);
        step_chk("rel2", 8'h01, 8'h00, 1'b1, 1'b0);

        // Zero hold-off returns straight to IDLE, then an error-channel edge.
        holdoff_i = 8'd0;
        ch_done_i = 8'h00;
        clr_we_i  = 1'b1;
        clr_i     = 8'hFF;
        step_chk("clr_all", 8'h00, 8'h00, 1'b1, 1'b0);
        clr_we_i  = 1'b0;
        step_chk("ho0_idle", 8'h00, 8'h00, 1'b0, 1'b0);
        ch_err_i  = 8'h02;
`ifdef WB_DMA_IRQ_CTRL_ERR_EN
        step_chk("err_set", 8'h00, 8'h02, 1'b0, 1'b0);
        step_chk("err_irq", 8'h00, 8'h02, 1'b1, 1'b0);
`else
        step_chk("err_set", 8'h02, 8'h00, 1'b0, 1'b0);
        step_chk("err_irq", 8'h02, 8'h00, 1'b1, 1'b0);
`endif
        clr_we_i  = 1'b1;
        clr_i     = 8'h02;
        step_chk("err_clr", 8'h00, 8'h00, 1'b1, 1'b0);
        clr_we_i  = 1'b0;
        step_chk("err_off", 8'h00, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
